// File: rtl/counter_checker_if.sv
// Bundle between a pad-side counter source and the counter_checker monitor.
// Ports: master drives q_i/enable/clear_err; slave drives locked/err_pulse/err_count/expected.
interface counter_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     q_i;
    logic                 enable;
    logic                 clear_err;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [WIDTH-1:0]     expected;

    modport master (
        output q_i, enable, clear_err,
        input  locked, err_pulse, err_count, expected
    );

    modport slave (
        input  q_i, enable, clear_err,
        output locked, err_pulse, err_count, expected
    );
endinterface

// File: rtl/counter_checker.sv
// Monitors a pad-level +1 count stream: synchronises it, locks on, counts sequence errors.
// Ports: clk, reset (sync, active-high), bus (slave): q_i, enable, clear_err in;
//        locked, err_pulse, err_count (saturating), expected (next value, 0 if unlocked) out.
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    counter_checker_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                              r_state;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]   r_sync;
    logic [WIDTH-1:0]                    r_prev;
    logic                                r_prev_valid;
    logic [RUN_W-1:0]                    r_run;
    logic                                r_locked;
    logic                                r_err_pulse;
    logic [ERR_CNT_W-1:0]                r_err_count;
    logic [WIDTH-1:0]                    r_expected;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_next;
    logic             w_match;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_lock_hit;
    logic             w_sat;
    logic             w_err;

    assign w_s        = r_sync[SYNC_STAGES-1];
    // Wraps naturally at WIDTH bits, so all-ones -> 0 is a legal step.
    assign w_next     = r_prev + 1'b1;
    assign w_match    = (w_s == w_next);
    assign w_run_inc  = r_run + 1'b1;
    assign w_lock_hit = (w_run_inc == RUN_W'(LOCK_COUNT));
    assign w_sat      = &r_err_count;
    assign w_err      = (r_state == LOCKED) && bus.enable && !w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sync       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_run        <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_count  <= '0;
            r_expected   <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.q_i};
            r_prev      <= w_s;
            r_err_pulse <= 1'b0;

            // Clear beats a coincident error; the pulse still fires.
            if (bus.clear_err) begin
                r_err_count <= '0;
            end else if (w_err && !w_sat) begin
                r_err_count <= r_err_count + 1'b1;
            end

            if (!bus.enable) begin
                r_state      <= IDLE;
                r_prev_valid <= 1'b0;
                r_run        <= '0;
                r_locked     <= 1'b0;
                r_expected   <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state      <= SEARCH;
                        r_prev_valid <= 1'b0;
                        r_run        <= '0;
                        r_locked     <= 1'b0;
                        r_expected   <= '0;
                    end
                    SEARCH: begin
                        if (!r_prev_valid) begin
                            // First cycle only primes prev.
                            r_prev_valid <= 1'b1;
                            r_run        <= '0;
                        end else if (w_match) begin
                            r_run <= w_run_inc;
                            if (w_lock_hit) begin
                                r_state    <= LOCKED;
                                r_locked   <= 1'b1;
                                r_expected <= w_s + 1'b1;
                            end
                        end else begin
                            r_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            r_expected <= w_s + 1'b1;
                        end else begin
                            // prev reloads from s, so the search resumes
                            // comparing on the very next sample.
                            r_state      <= SEARCH;
                            r_prev_valid <= 1'b1;
                            r_run        <= '0;
                            r_locked     <= 1'b0;
                            r_err_pulse  <= 1'b1;
                            r_expected   <= '0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
    assign bus.expected  = r_expected;
endmodule
